// File: rtl/duck_pkg.sv
// Shared state encoding, 65 MHz timing constants and the speed helper
// used by the duck round sequencer.
package duck_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INTRO     = 3'd1,
        ST_SPAWN     = 3'd2,
        ST_FLYING    = 3'd3,
        ST_GAP       = 3'd4,
        ST_EVAL      = 3'd5,
        ST_GAME_OVER = 3'd6
    } duck_state_e;

    localparam logic [31:0] INTRO_CYCLES_65M = 32'd195_000_000;
    localparam logic [31:0] FLY_CYCLES_65M   = 32'd390_000_000;
    localparam logic [31:0] GAP_CYCLES_65M   = 32'd130_000_000;
    localparam logic [2:0]  SPEED_MAX        = 3'd7;

    // Speed level is (round-1) plus any earned bonus, clamped to the top level.
    function automatic logic [2:0] calc_speed(input logic [3:0] round, input logic [2:0] bonus);
        logic [4:0] sum;
        sum = {1'b0, round} - 5'd1 + {2'b00, bonus};
        if (sum > {2'b00, SPEED_MAX}) begin
            return SPEED_MAX;
        end else begin
            return sum[2:0];
        end
    endfunction

endpackage

// File: rtl/duck_delay_timer.sv
// Saturating 32-bit down-counter shared by the intro, flight and gap phases.
// A load of N reports expired N+1 cycles later; it never wraps below zero.
module duck_delay_timer
    import duck_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] value,
    output logic        expired
);

    logic [31:0] count_r;
    logic [31:0] count_next_s;
    logic        expired_r;

    // Next count: load wins, otherwise decrement and hold at zero.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = value;
        end else if (count_r != 32'd0) begin
            count_next_s = count_r - 32'd1;
        end else begin
            count_next_s = 32'd0;
        end
    end

    // Count register with a registered zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r   <= 32'd0;
            expired_r <= 1'b1;
        end else begin
            count_r   <= count_next_s;
            expired_r <= (count_next_s == 32'd0);
        end
    end

    assign expired = expired_r;

endmodule

// File: rtl/duck_round_sequencer.sv
// Round/level scheduler: spawns and times ducks, grades each round and ends the game.
// Optional build macro DUCK_ROUND_PERFECT_BONUS_EN enables the perfect-round pulse and speed bonus.
module duck_round_sequencer
    import duck_pkg::*;
#(
    parameter int unsigned  DUCKS_PER_ROUND = 10,
    parameter int unsigned  PASS_HITS       = 6,
    parameter int unsigned  MAX_ROUND       = 15,
    parameter logic [31:0]  INTRO_CYCLES    = INTRO_CYCLES_65M,
    parameter logic [31:0]  FLY_CYCLES      = FLY_CYCLES_65M,
    parameter logic [31:0]  GAP_CYCLES      = GAP_CYCLES_65M
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        duck_killed,
    input  logic [6:0]  bullets_left,
    input  logic [2:0]  bullets_in_mag,
    output logic        game_enable,
    output logic        duck_spawn,
    output logic        duck_active,
    output logic        duck_escaped,
    output logic [3:0]  round_num,
    output logic [3:0]  duck_idx,
    output logic [15:0] hit_mask,
    output logic [3:0]  hits_round,
    output logic [2:0]  duck_speed,
    output logic        round_passed,
    output logic        game_over,
    output logic        perfect_round
);

    localparam logic [3:0] LAST_IDX  = 4'(DUCKS_PER_ROUND - 1);
    localparam logic [3:0] DUCKS_W   = 4'(DUCKS_PER_ROUND);
    localparam logic [3:0] PASS_W    = 4'(PASS_HITS);
    localparam logic [3:0] MAX_RND_W = 4'(MAX_ROUND);

    duck_state_e state_r, next_state_s;

    logic        start_prev_r;
    logic        start_rise_s;
    logic        ammo_empty_s;
    logic        timer_load_s;
    logic [31:0] timer_value_s;
    logic        timer_expired_s;

    logic [3:0]  round_r, round_next_s;
    logic [3:0]  idx_r, idx_next_s;
    logic [15:0] mask_r, mask_next_s;
    logic [3:0]  hits_r, hits_next_s;
    logic [2:0]  bonus_r, bonus_next_s;
    logic [2:0]  speed_r;
    logic        enable_r, spawn_r, active_r, escaped_r, passed_r, over_r, perfect_r;
    logic        passed_next_s, escaped_next_s, perfect_next_s;

    assign start_rise_s = start & ~start_prev_r;
    assign ammo_empty_s = (bullets_left == 7'd0) && (bullets_in_mag == 3'd0);

    duck_delay_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load_s),
        .value   (timer_value_s),
        .expired (timer_expired_s)
    );

    // Next-state, timer loads and per-round bookkeeping.
    always_comb begin
        next_state_s   = state_r;
        timer_load_s   = 1'b0;
        timer_value_s  = 32'd0;
        round_next_s   = round_r;
        idx_next_s     = idx_r;
        mask_next_s    = mask_r;
        hits_next_s    = hits_r;
        bonus_next_s   = bonus_r;
        passed_next_s  = 1'b0;
        escaped_next_s = 1'b0;
        perfect_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    next_state_s  = ST_INTRO;
                    timer_load_s  = 1'b1;
                    timer_value_s = INTRO_CYCLES;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INTRO: begin
                if (timer_expired_s) begin
                    next_state_s = ST_SPAWN;
                end else begin
                    next_state_s = ST_INTRO;
                end
            end
            ST_SPAWN: begin
                next_state_s  = ST_FLYING;
                timer_load_s  = 1'b1;
                timer_value_s = FLY_CYCLES;
            end
            ST_FLYING: begin
                // A kill outranks a simultaneous timeout or empty gun.
                if (duck_killed) begin
                    mask_next_s   = mask_r | (16'd1 << idx_r);
                    hits_next_s   = hits_r + 4'd1;
                    next_state_s  = ST_GAP;
                    timer_load_s  = 1'b1;
                    timer_value_s = GAP_CYCLES;
                end else if (timer_expired_s || ammo_empty_s) begin
                    escaped_next_s = 1'b1;
                    next_state_s   = ST_GAP;
                    timer_load_s   = 1'b1;
                    timer_value_s  = GAP_CYCLES;
                end else begin
                    next_state_s = ST_FLYING;
                end
            end
            ST_GAP: begin
                if (!timer_expired_s) begin
                    next_state_s = ST_GAP;
                end else if (idx_r == LAST_IDX) begin
                    next_state_s = ST_EVAL;
                end else begin
                    idx_next_s   = idx_r + 4'd1;
                    next_state_s = ST_SPAWN;
                end
            end
            ST_EVAL: begin
                if (hits_r >= PASS_W) begin
                    passed_next_s = 1'b1;
                    mask_next_s   = 16'd0;
                    hits_next_s   = 4'd0;
                    idx_next_s    = 4'd0;
                    round_next_s  = (round_r < MAX_RND_W) ? (round_r + 4'd1) : MAX_RND_W;
                    next_state_s  = ST_INTRO;
                    timer_load_s  = 1'b1;
                    timer_value_s = INTRO_CYCLES;
                end else begin
                    next_state_s = ST_GAME_OVER;
                end
`ifdef DUCK_ROUND_PERFECT_BONUS_EN
                if (hits_r == DUCKS_W) begin
                    perfect_next_s = 1'b1;
                    bonus_next_s   = (bonus_r < SPEED_MAX) ? (bonus_r + 3'd1) : SPEED_MAX;
                end else begin
                    perfect_next_s = 1'b0;
                end
`endif
            end
            ST_GAME_OVER: begin
                if (start_rise_s) begin
                    next_state_s = ST_IDLE;
                    round_next_s = 4'd1;
                    idx_next_s   = 4'd0;
                    mask_next_s  = 16'd0;
                    hits_next_s  = 4'd0;
                    bonus_next_s = 3'd0;
                end else begin
                    next_state_s = ST_GAME_OVER;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered outputs; rst restores power-up values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            start_prev_r <= 1'b0;
            round_r      <= 4'd1;
            idx_r        <= 4'd0;
            mask_r       <= 16'd0;
            hits_r       <= 4'd0;
            bonus_r      <= 3'd0;
            speed_r      <= 3'd0;
            enable_r     <= 1'b0;
            spawn_r      <= 1'b0;
            active_r     <= 1'b0;
            escaped_r    <= 1'b0;
            passed_r     <= 1'b0;
            over_r       <= 1'b0;
            perfect_r    <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            start_prev_r <= start;
            round_r      <= round_next_s;
            idx_r        <= idx_next_s;
            mask_r       <= mask_next_s;
            hits_r       <= hits_next_s;
            bonus_r      <= bonus_next_s;
            speed_r      <= calc_speed(round_next_s, bonus_next_s);
            enable_r     <= (next_state_s != ST_IDLE) && (next_state_s != ST_GAME_OVER);
            spawn_r      <= (next_state_s == ST_SPAWN);
            active_r     <= (next_state_s == ST_FLYING);
            escaped_r    <= escaped_next_s;
            passed_r     <= passed_next_s;
            over_r       <= (next_state_s == ST_GAME_OVER);
            perfect_r    <= perfect_next_s;
        end
    end

    assign game_enable   = enable_r;
    assign duck_spawn    = spawn_r;
    assign duck_active   = active_r;
    assign duck_escaped  = escaped_r;
    assign round_num     = round_r;
    assign duck_idx      = idx_r;
    assign hit_mask      = mask_r;
    assign hits_round    = hits_r;
    assign duck_speed    = speed_r;
    assign round_passed  = passed_r;
    assign game_over     = over_r;
    assign perfect_round = perfect_r;

endmodule

// File: tb/tb_duck_round_sequencer.sv
// Directed bench for duck_round_sequencer with short round timing (3 ducks, pass at 2 hits).
module tb_duck_round_sequencer;

    localparam int DUCKS = 3;
`ifdef DUCK_ROUND_PERFECT_BONUS_EN
    localparam int BONUS = 1;
`else
    localparam int BONUS = 0;
`endif
    // Steps from a spawn to the escape pulse: one SPAWN cycle, FLY+1 flight cycles, then the registered pulse.
    localparam int ESC_STEPS = 12;

    logic        clk = 1'b0;
    logic        rst, start, duck_killed;
    logic [6:0]  bullets_left;
    logic [2:0]  bullets_in_mag;
    logic        game_enable, duck_spawn, duck_active, duck_escaped;
    logic [3:0]  round_num, duck_idx, hits_round;
    logic [15:0] hit_mask;
    logic [2:0]  duck_speed;
    logic        round_passed, game_over, perfect_round;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    duck_round_sequencer #(
        .DUCKS_PER_ROUND (3),
        .PASS_HITS       (2),
        .MAX_ROUND       (15),
        .INTRO_CYCLES    (32'd4),
        .FLY_CYCLES      (32'd10),
        .GAP_CYCLES      (32'd2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .duck_killed(duck_killed),
        .bullets_left(bullets_left), .bullets_in_mag(bullets_in_mag),
        .game_enable(game_enable), .duck_spawn(duck_spawn), .duck_active(duck_active),
        .duck_escaped(duck_escaped), .round_num(round_num), .duck_idx(duck_idx),
        .hit_mask(hit_mask), .hits_round(hits_round), .duck_speed(duck_speed),
        .round_passed(round_passed), .game_over(game_over), .perfect_round(perfect_round)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_now(input int sel);
        case (sel)
            0:       return duck_spawn;
            1:       return duck_escaped;
            2:       return round_passed;
            3:       return game_over;
            default: return 1'b0;
        endcase
    endfunction

    // Steps until the selected output is seen high; gives up at 64.
    task automatic wait_on(input int sel, output int n);
        n = 0;
        while (sig_now(sel) !== 1'b1 && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic kill_current();
        step();
        step();
        duck_killed = 1'b1;
        step();
        duck_killed = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; duck_killed = 1'b0;
        bullets_left = 7'd20; bullets_in_mag = 3'd5;
        repeat (3) step();
        n_cmp++; if (round_num !== 4'd1) begin n_err++; $display("FAIL reset_round: got %0d want 1", round_num); end
        n_cmp++; if (game_enable !== 1'b0) begin n_err++; $display("FAIL reset_enable: got %0b want 0", game_enable); end
        n_cmp++; if (hit_mask !== 16'd0 || hits_round !== 4'd0) begin n_err++; $display("FAIL reset_mask: got %h/%0d want 0/0", hit_mask, hits_round); end
        n_cmp++; if ({duck_spawn, duck_active, duck_escaped, round_passed, game_over, perfect_round} !== 6'd0) begin
            n_err++; $display("FAIL reset_flags: got %b want 000000", {duck_spawn, duck_active, duck_escaped, round_passed, game_over, perfect_round}); end
        n_cmp++; if (duck_speed !== 3'd0 || duck_idx !== 4'd0) begin n_err++; $display("FAIL reset_speed_idx: got %0d/%0d want 0/0", duck_speed, duck_idx); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_start();
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (game_enable !== 1'b1) begin n_err++; $display("FAIL start_enable: got %0b want 1", game_enable); end
        n_cmp++; if (duck_spawn !== 1'b0) begin n_err++; $display("FAIL start_early_spawn: got %0b want 0", duck_spawn); end
        wait_on(0, n);
        n_cmp++; if (n !== 5) begin n_err++; $display("FAIL start_spawn_delay: got %0d want 5", n); end
        n_cmp++; if (round_num !== 4'd1 || duck_idx !== 4'd0) begin n_err++; $display("FAIL start_round_idx: got %0d/%0d want 1/0", round_num, duck_idx); end
    endtask

    task automatic test_kill_round();
        int n;
        logic [15:0] exp_mask;
        exp_mask = 16'd0;
        for (int i = 0; i < DUCKS; i++) begin
            if (i > 0) begin
                wait_on(0, n);
                n_cmp++; if (n !== 3) begin n_err++; $display("FAIL kill_gap_delay%0d: got %0d want 3", i, n); end
                n_cmp++; if (duck_idx !== 4'(i)) begin n_err++; $display("FAIL kill_idx%0d: got %0d want %0d", i, duck_idx, i); end
            end
            kill_current();
            exp_mask = exp_mask | (16'd1 << i);
            n_cmp++; if (hit_mask !== exp_mask || hits_round !== 4'(i + 1)) begin
                n_err++; $display("FAIL kill_mask%0d: got %h/%0d want %h/%0d", i, hit_mask, hits_round, exp_mask, i + 1); end
            n_cmp++; if (duck_escaped !== 1'b0 || duck_active !== 1'b0) begin
                n_err++; $display("FAIL kill_flags%0d: got esc=%0b act=%0b want 0/0", i, duck_escaped, duck_active); end
        end
        wait_on(2, n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL pass_delay: got %0d want 4", n); end
        n_cmp++; if (round_num !== 4'd2) begin n_err++; $display("FAIL pass_round: got %0d want 2", round_num); end
        n_cmp++; if (duck_speed !== 3'(1 + BONUS)) begin n_err++; $display("FAIL pass_speed: got %0d want %0d", duck_speed, 1 + BONUS); end
        n_cmp++; if (hit_mask !== 16'd0 || hits_round !== 4'd0 || duck_idx !== 4'd0) begin
            n_err++; $display("FAIL pass_clear: got %h/%0d/%0d want 0/0/0", hit_mask, hits_round, duck_idx); end
        n_cmp++; if (perfect_round !== 1'(BONUS)) begin n_err++; $display("FAIL pass_perfect: got %0b want %0d", perfect_round, BONUS); end
        n_cmp++; if (game_enable !== 1'b1) begin n_err++; $display("FAIL pass_enable: got %0b want 1", game_enable); end
        step();
        n_cmp++; if (round_passed !== 1'b0) begin n_err++; $display("FAIL pass_pulse_width: got %0b want 0", round_passed); end
    endtask

    task automatic test_escape_timeout();
        int n;
        for (int i = 0; i < DUCKS; i++) begin
            wait_on(0, n);
            wait_on(1, n);
            n_cmp++; if (n !== ESC_STEPS) begin n_err++; $display("FAIL escape_delay%0d: got %0d want %0d", i, n, ESC_STEPS); end
            n_cmp++; if (hit_mask !== 16'd0) begin n_err++; $display("FAIL escape_mask%0d: got %h want 0", i, hit_mask); end
        end
        wait_on(3, n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL over_delay: got %0d want 4", n); end
        n_cmp++; if (game_enable !== 1'b0 || round_passed !== 1'b0) begin
            n_err++; $display("FAIL over_enable: got en=%0b pass=%0b want 0/0", game_enable, round_passed); end
        n_cmp++; if (round_num !== 4'd2) begin n_err++; $display("FAIL over_round: got %0d want 2", round_num); end
    endtask

    task automatic test_restart();
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (game_over !== 1'b0 || game_enable !== 1'b0) begin
            n_err++; $display("FAIL restart_idle: got over=%0b en=%0b want 0/0", game_over, game_enable); end
        n_cmp++; if (round_num !== 4'd1 || duck_speed !== 3'd0) begin
            n_err++; $display("FAIL restart_round: got %0d/%0d want 1/0", round_num, duck_speed); end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (game_enable !== 1'b1) begin n_err++; $display("FAIL restart_enable: got %0b want 1", game_enable); end
    endtask

    task automatic test_ammo_and_ignored_start();
        int n;
        wait_on(0, n);
        step();
        bullets_left = 7'd0; bullets_in_mag = 3'd0;
        step();
        bullets_left = 7'd20; bullets_in_mag = 3'd5;
        n_cmp++; if (duck_escaped !== 1'b1 || hit_mask !== 16'd0) begin
            n_err++; $display("FAIL ammo_escape: got esc=%0b mask=%h want 1/0", duck_escaped, hit_mask); end
        wait_on(0, n);
        step();
        step();
        bullets_left = 7'd0; bullets_in_mag = 3'd0; duck_killed = 1'b1;
        step();
        bullets_left = 7'd20; bullets_in_mag = 3'd5; duck_killed = 1'b0;
        n_cmp++; if (duck_escaped !== 1'b0 || hit_mask !== 16'h0002 || hits_round !== 4'd1) begin
            n_err++; $display("FAIL ammo_kill_wins: got esc=%0b mask=%h hits=%0d want 0/0002/1", duck_escaped, hit_mask, hits_round); end
        wait_on(0, n);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_cmp++; if (duck_active !== 1'b1 || game_enable !== 1'b1 || round_num !== 4'd1 || duck_idx !== 4'd2) begin
            n_err++; $display("FAIL fly_start_ignored: got act=%0b en=%0b rnd=%0d idx=%0d want 1/1/1/2", duck_active, game_enable, round_num, duck_idx); end
        wait_on(1, n);
        n_cmp++; if (n !== ESC_STEPS - 3) begin n_err++; $display("FAIL fly_escape_delay: got %0d want %0d", n, ESC_STEPS - 3); end
        wait_on(3, n);
        n_cmp++; if (game_over !== 1'b1 || hit_mask !== 16'h0002) begin
            n_err++; $display("FAIL fail_round_over: got over=%0b mask=%h want 1/0002", game_over, hit_mask); end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (hit_mask !== 16'd0 || hits_round !== 4'd0 || duck_idx !== 4'd0 || round_num !== 4'd1 || game_over !== 1'b0) begin
            n_err++; $display("FAIL restart_clear: got mask=%h hits=%0d idx=%0d rnd=%0d over=%0b want 0/0/0/1/0", hit_mask, hits_round, duck_idx, round_num, game_over); end
        step();
    endtask

    task automatic test_perfect();
        int n;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < DUCKS; i++) begin
            wait_on(0, n);
            kill_current();
        end
        wait_on(2, n);
        n_cmp++; if (perfect_round !== 1'(BONUS)) begin n_err++; $display("FAIL perfect_pulse: got %0b want %0d", perfect_round, BONUS); end
        n_cmp++; if (duck_speed !== 3'(1 + BONUS) || round_num !== 4'd2) begin
            n_err++; $display("FAIL perfect_speed: got spd=%0d rnd=%0d want %0d/2", duck_speed, round_num, 1 + BONUS); end
        step();
        n_cmp++; if (perfect_round !== 1'b0) begin n_err++; $display("FAIL perfect_width: got %0b want 0", perfect_round); end
    endtask

    task automatic test_reset_abort();
        int n;
        wait_on(0, n);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (round_num !== 4'd1 || duck_speed !== 3'd0 || duck_active !== 1'b0 || game_enable !== 1'b0) begin
            n_err++; $display("FAIL abort_values: got rnd=%0d spd=%0d act=%0b en=%0b want 1/0/0/0", round_num, duck_speed, duck_active, game_enable); end
        repeat (3) step();
        n_cmp++; if (game_enable !== 1'b0 || duck_spawn !== 1'b0) begin
            n_err++; $display("FAIL abort_stays_idle: got en=%0b spawn=%0b want 0/0", game_enable, duck_spawn); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_kill_round();
        test_escape_timeout();
        test_restart();
        test_ammo_and_ignored_start();
        test_perfect();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
